master_in_port: RTL and testbench
=================================

Name: master_in_port

Overview:
- Receive-side partner of the slave output port. Deserializes the LSB-first serial frame that the slave port drives on its tx_data/slave_tx_done lines back into a parallel word.
- Drives master_ready back to the slave port and gates new frames with it.
- Holds one completed word in an output register with a valid/ready handshake toward the bus master logic.
- Detects malformed or stalled frames.

Parameters:
- DATA_W, 8, frame payload width in bits; must be >= 2.
- TIMEOUT, 16, max idle cycles between consecutive bits inside a frame before abort; must be >= 1.
- CNT_W, $clog2(DATA_W)+1, bit-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rx_data  in  1  serial data bit from slave output port (tx_data).
- rx_valid  in  1  rx_data holds a valid bit this cycle.
- rx_done  in  1  slave_tx_done; high together with the last bit of a frame.
- master_ready  out  1  receiver can accept a new frame; wired to slave port.
- dout  out  DATA_W  assembled word, bit 0 = first bit received.
- dout_valid  out  1  dout holds an unread word.
- dout_ready  in  1  consumer accepts dout this cycle.
- frame_err  out  1  one-cycle pulse: frame aborted.
- busy  out  1  high while state is RECEIVE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bit_cnt=0; shreg=0; dout=0.
  - dout_valid=0; frame_err=0; timeout counter=0.
  - master_ready=0 while reset is asserted; it follows the rule below from the first clock after release.
- master_ready = (state==IDLE) && !dout_valid, combinational.
- States:
  - IDLE:
    - Stay in IDLE while rx_valid=0.
    - On rx_valid=1 with dout_valid=0: write rx_data into shreg[0], set bit_cnt=1, clear the timeout counter, go to RECEIVE.
    - On rx_valid=1 with dout_valid=1 (protocol violation, word not yet read): pulse frame_err, ignore the bit, stay in IDLE.
  - RECEIVE:
    - On rx_valid=1: write rx_data into shreg[bit_cnt], increment bit_cnt, clear the timeout counter.
      - Bit with rx_done=1 and bit_cnt==DATA_W-1: frame complete. On the next edge, dout takes the full word (including this bit), dout_valid=1, bit_cnt=0, go to IDLE.
      - Bit with rx_done=1 and bit_cnt<DATA_W-1 (short frame): pulse frame_err, discard, bit_cnt=0, go to IDLE.
      - Bit with rx_done=0 and bit_cnt==DATA_W-1 (long frame, no done): pulse frame_err, discard, go to IDLE.
    - On rx_valid=0: increment the timeout counter. When it reaches TIMEOUT: pulse frame_err, discard, bit_cnt=0, go to IDLE.
- rx_done with rx_valid=0 is ignored in every state.
- Single-frame latency: dout_valid rises on the first edge after the last-bit cycle. With the slave port streaming, the handshake is at cycle N, bits arrive at N+1..N+DATA_W, and dout_valid=1 at N+DATA_W+1.
- Output handshake:
  - dout_valid clears on an edge where dout_ready=1.
  - dout is stable while dout_valid=1.
  - dout_ready while dout_valid=0 has no effect.
- Simultaneous events:
  - If the frame-complete load and dout_ready with dout_valid=1 fall on the same edge, the load wins and dout_valid stays 1. This case is unreachable under correct protocol, because master_ready is low.
  - A consumer read and master_ready rise are one cycle apart: a read at edge E gives master_ready=1 after E.
- frame_err is registered, high for exactly one cycle per error.
- shreg is not cleared on abort; stale bits are overwritten by the next frame.
- Reset mid-frame: the partial word is lost, no frame_err pulse, and dout_valid=0.

Decomposition:
- Shared bus package holds:
  - State encodings IDLE/RECEIVE as localparams, consistent with the bus's 4-bit state style.
  - Default DATA_W=8.
  - Default TIMEOUT value.
- One natural sub-module: master_in_shreg, the DATA_W indexed-write capture register with bit counter and clear. The FSM, timeout counter and output register stay in the top module.

Test Plan:
- Reset, then a frame of 8 bits 1,0,1,1,0,0,1,0 (LSB first) with rx_done on the 8th bit, dout_ready=1 -> dout=8'h4D and dout_valid high for exactly 1 cycle, at the edge after the last bit; frame_err stays 0.
- Frame 8'hA5 with dout_ready=0 -> master_ready=0 and dout=8'hA5 held. Raise dout_ready for 1 cycle -> dout_valid=0 and master_ready=1 the next cycle. Then send a second frame 8'h3C -> dout=8'h3C.
- rx_done asserted on the 5th bit -> frame_err pulse 1 cycle, dout_valid stays 0, busy=0. A following good frame 8'hFF is received correctly.
- rx_valid stops after 3 bits for 16 cycles -> frame_err pulse on the 16th idle cycle, return to IDLE, master_ready=1.
- Assert reset=0 after bit 4 of a frame -> all outputs at reset values immediately (asynchronous). Release and send 8'h81 -> dout=8'h81 with no frame_err.
- rx_valid while dout_valid=1 and dout_ready=0 -> frame_err pulse, dout unchanged.

Source files
------------

// File: rtl/master_in_port_pkg.sv
// Shared definitions for the master input port.
// Holds the receiver state encodings (the bus uses 4-bit state codes)
// and the default frame width and inter-bit timeout.
package master_in_port_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [3:0] ST_IDLE    = 4'h0;
  localparam logic [3:0] ST_RECEIVE = 4'h1;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    RECEIVE = ST_RECEIVE
  } mip_state_e;

endpackage

// File: rtl/master_in_port_if.sv
// Signal bundle between the master input port, the slave output port
// that streams serial frames into it, and the consumer of assembled words.
//   rx_data/rx_valid/rx_done : serial bit, bit strobe, last-bit marker
//   master_ready             : receiver may accept a new frame
//   dout/dout_valid/dout_ready : parallel word handshake toward the consumer
//   frame_err                : one-cycle abort pulse
//   busy                     : a frame is being received
// modport master : the receiver (master_in_port)
// modport slave  : the serial source plus the word consumer
interface master_in_port_if
  import master_in_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              rx_data;
  logic              rx_valid;
  logic              rx_done;
  logic              master_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              busy;

  modport master (
    input  rx_data, rx_valid, rx_done, dout_ready,
    output master_ready, dout, dout_valid, frame_err, busy
  );

  modport slave (
    output rx_data, rx_valid, rx_done, dout_ready,
    input  master_ready, dout, dout_valid, frame_err, busy
  );

endinterface

// File: rtl/master_in_port_shreg.sv
// Capture register for the master input port: an indexed-write shift
// register plus the bit counter that selects the write position.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   wr_i          : store bit_i this cycle
//   start_i       : write goes to bit 0 (first bit of a frame)
//   clr_i         : bit counter returns to 0 on this edge
//   bit_i         : serial data bit
//   word_next_o   : register contents including this cycle's write
//   bit_cnt_o     : next write position
module master_in_shreg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_i,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_next_o,
  output logic [CNT_W-1:0]  bit_cnt_o
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx;

  assign idx = start_i ? '0 : cnt_q;

  always_comb begin
    shreg_d = shreg_q;
    if (wr_i) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (idx == CNT_W'(i)) shreg_d[i] = bit_i;
      end
    end
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (wr_i) cnt_d = idx + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The completing bit is folded in combinationally so the output word
  // can be loaded on the same edge that samples the last bit.
  assign word_next_o = shreg_d;
  assign bit_cnt_o   = cnt_q;

endmodule

// File: rtl/master_in_port.sv
// Master input port: deserializes LSB-first frames from the slave output
// port, holds one finished word for the consumer, and aborts short, long
// or stalled frames with a one-cycle frame_err pulse.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : master_in_port_if.master (serial input, word output, status)
module master_in_port
  import master_in_port_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W   = $clog2(DATA_W) + 1,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  master_in_port_if.master bus
);

  mip_state_e        state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              sh_wr, sh_start, sh_clr;
  logic [DATA_W-1:0] word_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;

  master_in_shreg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shreg (
    .clk         (clk),
    .reset       (reset),
    .wr_i        (sh_wr),
    .start_i     (sh_start),
    .clr_i       (sh_clr),
    .bit_i       (bus.rx_data),
    .word_next_o (word_next),
    .bit_cnt_o   (bit_cnt)
  );

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    sh_wr        = 1'b0;
    sh_start     = 1'b0;
    sh_clr       = 1'b0;

    if (dout_valid_q && bus.dout_ready) dout_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (dout_valid_q) begin
            // Previous word still unread: the bit is dropped.
            frame_err_d = 1'b1;
          end else begin
            sh_wr    = 1'b1;
            sh_start = 1'b1;
            to_d     = '0;
            state_d  = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        if (bus.rx_valid) begin
          sh_wr = 1'b1;
          to_d  = '0;
          if (bus.rx_done) begin
            sh_clr  = 1'b1;
            state_d = IDLE;
            if (last_bit) begin
              // Load overrides a same-edge consumer read.
              dout_d       = word_next;
              dout_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else if (last_bit) begin
            frame_err_d = 1'b1;
            sh_clr      = 1'b1;
            state_d     = IDLE;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          sh_clr      = 1'b1;
          to_d        = '0;
          state_d     = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      to_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // reset is folded in so master_ready is low while reset is held.
  assign bus.master_ready = reset && (state_q == IDLE) && !dout_valid_q;
  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.busy         = (state_q == RECEIVE);

endmodule

// File: tb/tb_master_in_port.sv
// Directed bench for master_in_port with hand-computed expected words.
module tb_master_in_port;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   ferr_cnt;
  int   ferr_base;

  master_in_port_if #(.DATA_W(8)) bus ();

  master_in_port #(
    .DATA_W  (8),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_err cycles, sampled away from the active edge.
  always @(negedge clk) if (bus.frame_err) ferr_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Streams n bits of w, LSB first; rx_done on the last bit when done=1.
  // Returns 1 time unit after the edge that sampled the last bit.
  task automatic send_frame(input logic [7:0] w, input int n, input bit done);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = w[i];
      bus.rx_done  = done && (i == n - 1);
      step();
    end
    bus.rx_valid = 1'b0;
    bus.rx_done  = 1'b0;
    bus.rx_data  = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    ferr_cnt     = 0;
    reset        = 1'b0;
    bus.rx_data  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_done  = 1'b0;
    bus.dout_ready = 1'b1;

    // Reset state
    #2;
    check_val("rst_dout", bus.dout, 32'h0);
    check_val("rst_dv", bus.dout_valid, 0);
    check_val("rst_ferr", bus.frame_err, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_mready", bus.master_ready, 0);
    idle(2);
    reset = 1'b1;
    step();
    check_val("mready_after_rst", bus.master_ready, 1);

    // Frame 1,0,1,1,0,0,1,0 -> 8'h4D, consumer ready
    ferr_base = ferr_cnt;
    send_frame(8'h4D, 8, 1'b1);
    check_val("f1_dv", bus.dout_valid, 1);
    check_val("f1_dout", bus.dout, 32'h4D);
    check_val("f1_mready_low", bus.master_ready, 0);
    check_val("f1_busy", bus.busy, 0);
    step();
    check_val("f1_dv_one_cycle", bus.dout_valid, 0);
    check_val("f1_mready_back", bus.master_ready, 1);
    check_val("f1_no_err", ferr_cnt - ferr_base, 0);

    // Frame 8'hA5 held until read, then 8'h3C
    bus.dout_ready = 1'b0;
    send_frame(8'hA5, 8, 1'b1);
    idle(3);
    check_val("f2_dout_held", bus.dout, 32'hA5);
    check_val("f2_dv_held", bus.dout_valid, 1);
    check_val("f2_mready_low", bus.master_ready, 0);
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    check_val("f2_dv_cleared", bus.dout_valid, 0);
    check_val("f2_mready_up", bus.master_ready, 1);
    send_frame(8'h3C, 8, 1'b1);
    check_val("f3_dout", bus.dout, 32'h3C);
    check_val("f3_dv", bus.dout_valid, 1);
    bus.dout_ready = 1'b1;
    step();

    // Short frame: rx_done on 5th bit
    ferr_base = ferr_cnt;
    send_frame(8'h15, 5, 1'b1);
    check_val("short_ferr", bus.frame_err, 1);
    check_val("short_dv", bus.dout_valid, 0);
    check_val("short_busy", bus.busy, 0);
    step();
    check_val("short_ferr_pulse", ferr_cnt - ferr_base, 1);
    send_frame(8'hFF, 8, 1'b1);
    check_val("ff_dout", bus.dout, 32'hFF);
    check_val("ff_dv", bus.dout_valid, 1);
    step();

    // Long frame: 8 bits without rx_done
    ferr_base = ferr_cnt;
    send_frame(8'h66, 8, 1'b0);
    check_val("long_ferr", bus.frame_err, 1);
    check_val("long_dv", bus.dout_valid, 0);
    check_val("long_dout_kept", bus.dout, 32'hFF);
    step();
    check_val("long_ferr_pulse", ferr_cnt - ferr_base, 1);

    // Stall after 3 bits
    ferr_base = ferr_cnt;
    send_frame(8'h07, 3, 1'b0);
    idle(15);
    check_val("to_not_yet", bus.frame_err, 0);
    check_val("to_busy", bus.busy, 1);
    step();
    check_val("to_ferr", bus.frame_err, 1);
    check_val("to_busy_off", bus.busy, 0);
    check_val("to_mready", bus.master_ready, 1);
    step();
    check_val("to_ferr_pulse", ferr_cnt - ferr_base, 1);

    // Asynchronous reset after bit 4
    ferr_base = ferr_cnt;
    send_frame(8'hFF, 4, 1'b0);
    check_val("mid_busy", bus.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_busy", bus.busy, 0);
    check_val("arst_dout", bus.dout, 32'h0);
    check_val("arst_dv", bus.dout_valid, 0);
    check_val("arst_mready", bus.master_ready, 0);
    check_val("arst_ferr", bus.frame_err, 0);
    step();
    reset = 1'b1;
    step();
    send_frame(8'h81, 8, 1'b1);
    check_val("r81_dout", bus.dout, 32'h81);
    check_val("r81_dv", bus.dout_valid, 1);
    check_val("r81_no_err", ferr_cnt - ferr_base, 0);
    step();

    // Bit arrives while a word is unread
    bus.dout_ready = 1'b0;
    send_frame(8'h5A, 8, 1'b1);
    check_val("ov_dv", bus.dout_valid, 1);
    ferr_base = ferr_cnt;
    send_frame(8'h01, 1, 1'b0);
    check_val("ov_ferr", bus.frame_err, 1);
    check_val("ov_dout", bus.dout, 32'h5A);
    check_val("ov_busy", bus.busy, 0);
    step();
    check_val("ov_ferr_pulse", ferr_cnt - ferr_base, 1);
    check_val("ov_dv_held", bus.dout_valid, 1);
    bus.dout_ready = 1'b1;
    step();
    check_val("ov_dv_read", bus.dout_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
